// File: rtl/ram_op_issuer.sv
// Command FIFO and sequencer in front of ram_controller; one result held at a time.
// Optional build macro OP_TIMEOUT_EN adds an abort counter for stuck controller ops.
module ram_op_issuer #(
    parameter int DEPTH          = 8,
    parameter int ARG_W          = 10,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [ARG_W-1:0]         cmd_arg1,
    input  logic [ARG_W-1:0]         cmd_arg2,
    output logic [$clog2(DEPTH):0]   cmd_count,
    output logic                     ctrl_enable,
    output logic [1:0]               ctrl_select_op,
    output logic [ARG_W-1:0]         ctrl_arg1,
    output logic [ARG_W-1:0]         ctrl_arg2,
    input  logic                     ctrl_finished_op,
    input  logic [31:0]              ctrl_out1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [1:0]               rsp_op,
    output logic [31:0]              rsp_data,
    output logic                     rsp_error,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    logic [1:0]       op_mem [DEPTH];
    logic [ARG_W-1:0] a1_mem [DEPTH];
    logic [ARG_W-1:0] a2_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             push, pop, empty;

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       op_q, op_d;
    logic [ARG_W-1:0] a1_q, a1_d, a2_q, a2_d;
    logic             rv_q, rv_d;
    logic [1:0]       rop_q, rop_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rerr_q, rerr_d;

`ifdef OP_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES+1) > 10) ? $clog2(TIMEOUT_CYCLES+1) : 10;
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] tmr_q, tmr_d;
`endif

    assign cmd_ready = (count_q != FULL_CNT);
    assign empty     = (count_q == '0);
    assign push      = cmd_valid && cmd_ready;
    assign count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge clock) begin
        if (push) begin
            op_mem[wr_ptr_q] <= cmd_op;
            a1_mem[wr_ptr_q] <= cmd_arg1;
            a2_mem[wr_ptr_q] <= cmd_arg2;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        op_d    = op_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        rv_d    = rv_q;
        rop_d   = rop_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        pop     = 1'b0;
`ifdef OP_TIMEOUT_EN
        tmr_d   = tmr_q;
`endif
        if (rv_q && rsp_ready) rv_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !rv_q && ctrl_finished_op) begin
                    pop = 1'b1;
                    if (op_mem[rd_ptr_q] == 2'd3) begin
                        rv_d    = 1'b1;
                        rop_d   = 2'd3;
                        rdata_d = '0;
                        rerr_d  = 1'b1;
                    end else begin
                        op_d    = op_mem[rd_ptr_q];
                        a1_d    = a1_mem[rd_ptr_q];
                        a2_d    = a2_mem[rd_ptr_q];
                        en_d    = 1'b1;
                        state_d = ISSUE;
`ifdef OP_TIMEOUT_EN
                        tmr_d   = '0;
`endif
                    end
                end
            end
            ISSUE, WAIT_DONE: begin
`ifdef OP_TIMEOUT_EN
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == T_LIMIT) begin
                    en_d    = 1'b0;
                    rv_d    = 1'b1;
                    rop_d   = op_q;
                    rdata_d = '1;
                    rerr_d  = 1'b1;
                    state_d = IDLE;
                end else
`endif
                if (state_q == ISSUE) begin
                    if (!ctrl_finished_op) begin
                        en_d    = 1'b0;
                        state_d = WAIT_DONE;
                    end
                end else if (ctrl_finished_op) begin
                    rv_d    = 1'b1;
                    rop_d   = op_q;
                    rdata_d = ctrl_out1;
                    rerr_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            op_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            rv_q    <= 1'b0;
            rop_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            op_q    <= op_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            rv_q    <= rv_d;
            rop_q   <= rop_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

`ifdef OP_TIMEOUT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) tmr_q <= '0;
        else         tmr_q <= tmr_d;
    end
`endif

    assign cmd_count      = count_q;
    assign ctrl_enable    = en_q;
    assign ctrl_select_op = op_q;
    assign ctrl_arg1      = a1_q;
    assign ctrl_arg2      = a2_q;
    assign rsp_valid      = rv_q;
    assign rsp_op         = rop_q;
    assign rsp_data       = rdata_q;
    assign rsp_error      = rerr_q;
    assign busy           = (state_q != IDLE) || !empty;
endmodule
